// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that issues one single-cycle uart write strobe per byte, CLKS_PER_BYTE apart.
// Define UART_TX_FIFO_OVF_EN to build the sticky overflow flag; otherwise overflow_o is tied low.
module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int CLKS_PER_BYTE = 1042
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [7:0]             wr_data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   uart_we_o,
  output logic [7:0]             uart_data_o,
  output logic                   overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(CLKS_PER_BYTE);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(CLKS_PER_BYTE - 1);

  typedef enum logic {IDLE, GAP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [GW-1:0] gap;
  logic          push;
  logic          pop;
  logic [LW-1:0] level_nxt;

  // Full is the registered flag, so a pop in the same cycle never frees room for a push.
  always_comb begin
    push      = wr_en_i && !full_o;
    pop       = (state == IDLE) && !empty_o;
    level_nxt = level_o;
    if (push && !pop)
      level_nxt = level_o + LW'(1);
    else if (pop && !push)
      level_nxt = level_o - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      full_o      <= 1'b0;
      empty_o     <= 1'b1;
      state       <= IDLE;
      gap         <= '0;
      uart_we_o   <= 1'b0;
      uart_data_o <= 8'h00;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      level_o <= level_nxt;
      full_o  <= (level_nxt == LVL_FULL);
      empty_o <= (level_nxt == '0);
      case (state)
        IDLE: begin
          if (pop) begin
            uart_we_o   <= 1'b1;
            uart_data_o <= mem[rd_ptr];
            rd_ptr      <= rd_ptr + AW'(1);
            gap         <= GAP_LOAD;
            state       <= GAP;
          end else begin
            uart_we_o <= 1'b0;
          end
        end
        GAP: begin
          // Leaving on the edge where gap hits 0 puts the next strobe exactly CLKS_PER_BYTE later.
          uart_we_o <= 1'b0;
          gap       <= gap - GW'(1);
          if (gap == GW'(1))
            state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clk) begin
    if (rst)
      overflow_o <= 1'b0;
    else if (wr_en_i && full_o)
      overflow_o <= 1'b1;
  end
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (DEPTH=4, CLKS_PER_BYTE=8): cycle table plus corner sequences.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int CPB   = 8;
`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, uart_we, overflow;
  logic [2:0] level;
  logic [7:0] uart_data;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  logic [7:0] got_q[$];
  int         got_t[$];

  typedef struct {
    int         n;
    logic       w;
    logic [7:0] d;
    logic       we;
    logic [7:0] dat;
    logic [2:0] lvl;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;
  vec_t tbl[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .CLKS_PER_BYTE(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
    .uart_we_o  (uart_we),
    .uart_data_o(uart_data),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (uart_we === 1'b1) begin
      got_q.push_back(uart_data);
      got_t.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input int n, input logic w, input logic [7:0] d, input logic we,
                     input logic [7:0] dat, input logic [2:0] lvl, input logic f,
                     input logic e, input logic o);
    vec_t v;
    v.n = n; v.w = w; v.d = d; v.we = we; v.dat = dat;
    v.lvl = lvl; v.full = f; v.empty = e; v.ovf = o;
    tbl.push_back(v);
  endtask

  function automatic logic [14:0] obs();
    return {uart_we, uart_data, level, full, empty, overflow};
  endfunction

  localparam logic [14:0] RST_OBS = {1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [7:0] expb [$];
    int         d;

    wr_en = 1'b0; wr_data = 8'h00; rst = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("reset_state", obs(), RST_OBS);

    // One row per cycle span: inputs before the edge, outputs after it.
    add(1, 1, 8'h41, 0, 8'h00, 3'd1, 0, 0, 0);
    add(1, 0, 8'h00, 1, 8'h41, 3'd0, 0, 1, 0);
    add(1, 1, 8'h01, 0, 8'h41, 3'd1, 0, 0, 0);
    add(1, 1, 8'h02, 0, 8'h41, 3'd2, 0, 0, 0);
    add(1, 1, 8'h03, 0, 8'h41, 3'd3, 0, 0, 0);
    add(1, 1, 8'h04, 0, 8'h41, 3'd4, 1, 0, 0);
    add(2, 1, 8'hEE, 0, 8'h41, 3'd4, 1, 0, OVF);
    add(1, 0, 8'h00, 0, 8'h41, 3'd4, 1, 0, OVF);
    add(1, 0, 8'h00, 1, 8'h01, 3'd3, 0, 0, OVF);
    add(7, 0, 8'h00, 0, 8'h01, 3'd3, 0, 0, OVF);
    add(1, 0, 8'h00, 1, 8'h02, 3'd2, 0, 0, OVF);
    add(7, 0, 8'h00, 0, 8'h02, 3'd2, 0, 0, OVF);
    add(1, 1, 8'h07, 1, 8'h03, 3'd2, 0, 0, OVF);
    add(7, 0, 8'h00, 0, 8'h03, 3'd2, 0, 0, OVF);
    add(1, 0, 8'h00, 1, 8'h04, 3'd1, 0, 0, OVF);
    add(7, 0, 8'h00, 0, 8'h04, 3'd1, 0, 0, OVF);
    add(1, 0, 8'h00, 1, 8'h07, 3'd0, 0, 1, OVF);
    add(3, 0, 8'h00, 0, 8'h07, 3'd0, 0, 1, OVF);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].w, tbl[i].d, 1'b0);
        chk($sformatf("table_row%0d_rep%0d", i, k), obs(),
            {tbl[i].we, tbl[i].dat, tbl[i].lvl, tbl[i].full, tbl[i].empty, tbl[i].ovf});
      end
    end

    // Push while full on a strobe cycle: byte dropped, pop still happens.
    step(1'b0, 8'h00, 1'b1);
    chk("reset_clears_sticky", obs(), RST_OBS);
    got_q.delete(); got_t.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA1 + 8'(i), 1'b0);
    chk("full_after_fill", {level, full, overflow}, {3'd4, 1'b1, 1'b0});
    repeat (4) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hF6, 1'b0);
    chk("push_full_on_strobe", obs(), {1'b1, 8'hA2, 3'd3, 1'b0, 1'b0, OVF});
    repeat (30) step(1'b0, 8'h00, 1'b0);
    chk("drop_strobe_count", got_q.size(), 5);
    for (int i = 0; i < got_q.size() && i < 5; i++)
      chk($sformatf("drop_byte%0d", i), got_q[i], 8'hA1 + 8'(i));
    for (int i = 1; i < got_t.size(); i++)
      chk($sformatf("drop_spacing%0d", i), got_t[i] - got_t[i-1], CPB);

    // Reset during GAP with three bytes queued.
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    chk("mid_level_before_rst", {level, empty}, {3'd3, 1'b0});
    step(1'b0, 8'h00, 1'b1);
    chk("mid_reset_outputs", obs(), RST_OBS);
    got_q.delete(); got_t.delete();
    repeat (12) step(1'b0, 8'h00, 1'b0);
    chk("no_strobe_after_rst", got_q.size(), 0);
    step(1'b1, 8'h55, 1'b0);
    chk("post_rst_push", obs(), {1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0});
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_strobe", obs(), {1'b1, 8'h55, 3'd0, 1'b0, 1'b1, 1'b0});

    // Pointer wrap: 12 bytes in groups of 3.
    step(1'b0, 8'h00, 1'b1);
    got_q.delete(); got_t.delete();
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 8'h10 + 8'(g * 3 + i), 1'b0);
        expb.push_back(8'h10 + 8'(g * 3 + i));
      end
      repeat (27) step(1'b0, 8'h00, 1'b0);
    end
    chk("wrap_count", got_q.size(), 12);
    for (int i = 0; i < got_q.size() && i < expb.size(); i++)
      chk($sformatf("wrap_byte%0d", i), got_q[i], expb[i]);
    for (int i = 1; i < got_t.size(); i++) begin
      d = got_t[i] - got_t[i-1];
      chk($sformatf("wrap_spacing%0d", i), 32'(d >= CPB), 32'd1);
    end
    chk("wrap_drained", {level, empty, full}, {3'd0, 1'b1, 1'b0});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
